// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
package id_hazard_scoreboard_pkg;

  // Register address width; register 0 is hardwired to zero.
  localparam int REG_AW = 5;

  // Forwarding mux select encodings for the EX operand muxes.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // One in-flight register writer sitting in a pipeline stage.
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] addr;
    logic              is_load;
  } stage_entry_t;

  // Stage / source indices used to address the match vectors.
  localparam int ST_EX   = 0;
  localparam int ST_MEM  = 1;
  localparam int SRC_RS  = 0;
  localparam int SRC_RT  = 1;

endpackage

// File: rtl/id_hazard_scoreboard_match.sv
// Compares one stage entry against one ID source address; register 0 never hits.
module hazard_reg_match
  import id_hazard_scoreboard_pkg::*;
(
  input  stage_entry_t      entry,
  input  logic [REG_AW-1:0] addr,
  output logic              hit,
  output logic              hit_load
);

  assign hit      = entry.vld && (entry.addr == addr) && (addr != '0);
  assign hit_load = hit && entry.is_load;

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Tracks register writers in EX/MEM, decides ID stalls and forwarding selects.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_jr,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic              jr_fwd_sel,
  output logic [1:0]        ex_rs_sel,
  output logic [1:0]        ex_rt_sel,
  output logic [CNT_W-1:0]  stall_count
);

  // Index 0 = EX entry, 1 = MEM entry. A writer in WB needs no action because
  // the register file is write-through, so no WB entry is kept.
  stage_entry_t      stage_reg [2];
  stage_entry_t      ex_entry_next;
  logic [REG_AW-1:0] src_addr [2];
  logic [3:0]        hit;
  logic [3:0]        hit_load;
  logic [3:0]        load_mask;
  logic [3:0]        alu_mask;
  logic              rs_rd;
  logic              rt_rd;
  logic              jr_rd;
  logic              hazard;
  logic              advance;
  logic [1:0]        rs_sel_next;
  logic [1:0]        rt_sel_next;
  logic [1:0]        ex_rs_sel_reg;
  logic [1:0]        ex_rt_sel_reg;
  logic [CNT_W-1:0]  stall_count_reg;

  assign src_addr[SRC_RS] = id_rs_addr;
  assign src_addr[SRC_RT] = id_rt_addr;

  // One comparator per (stage, source); bit index = stage*2 + source.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_match
      hazard_reg_match u_match (
        .entry    (stage_reg[gi / 2]),
        .addr     (src_addr[gi % 2]),
        .hit      (hit[gi]),
        .hit_load (hit_load[gi])
      );
    end
  endgenerate

  // Stall / jr forward decision and EX select computation for the ID instruction.
  always_comb begin
    rs_rd = id_valid && id_uses_rs;
    rt_rd = id_valid && id_uses_rt;
    jr_rd = id_valid && id_is_jr;

    // Loads in EX block any reader; a load in MEM only blocks the jr target,
    // since EX operands can take it from MEM/WB next cycle.
    load_mask = {1'b0, jr_rd, rt_rd, rs_rd};
    // Any EX writer blocks jr: its result exists only at the end of EX.
    alu_mask  = {3'b000, jr_rd};
    hazard    = (|(hit_load & load_mask)) || (|(hit & alu_mask));

    stall      = !reset && id_valid && !flush && hazard;
    jr_fwd_sel = !reset && jr_rd && hit[ST_MEM*2+SRC_RS] && !hit_load[ST_MEM*2+SRC_RS];

    // Youngest writer wins: EX stage beats MEM stage.
    rs_sel_next = FWD_RF;
    if (rs_rd) begin
      if (hit[ST_EX*2+SRC_RS])       rs_sel_next = FWD_EXMEM;
      else if (hit[ST_MEM*2+SRC_RS]) rs_sel_next = FWD_MEMWB;
    end
    rt_sel_next = FWD_RF;
    if (rt_rd) begin
      if (hit[ST_EX*2+SRC_RT])       rt_sel_next = FWD_EXMEM;
      else if (hit[ST_MEM*2+SRC_RT]) rt_sel_next = FWD_MEMWB;
    end

    advance       = id_valid && !stall && !flush;
    ex_entry_next = '0;
    if (advance) begin
      ex_entry_next.vld     = id_wr_en && (id_wr_addr != '0);
      ex_entry_next.addr    = id_wr_addr;
      ex_entry_next.is_load = id_is_load;
    end
  end

  // Advance the writer pipeline and capture EX selects; bubble on stall/flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg[ST_EX]  <= '0;
      stage_reg[ST_MEM] <= '0;
      ex_rs_sel_reg     <= FWD_RF;
      ex_rt_sel_reg     <= FWD_RF;
    end else begin
      stage_reg[ST_MEM] <= stage_reg[ST_EX];
      stage_reg[ST_EX]  <= ex_entry_next;
      ex_rs_sel_reg     <= advance ? rs_sel_next : FWD_RF;
      ex_rt_sel_reg     <= advance ? rt_sel_next : FWD_RF;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (stall && (stall_count_reg != '1)) begin
      stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign ex_rs_sel   = ex_rs_sel_reg;
  assign ex_rt_sel   = ex_rt_sel_reg;
  assign stall_count = stall_count_reg;

endmodule
